// File: rtl/pt2262_tx_sequencer.sv
// PT2262 frame sequencer: alpha clock-enable prescaler, trit serialiser and
// sync/repeat control producing a registered DOUT waveform on a single clock.
module pt2262_tx_sequencer #(
  parameter int DIVIDER = 250,
  parameter int CNT_W   = 16
) (
  input  logic        INPUT_CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [23:0] CODE,
  input  logic [3:0]  FRAME_COUNT,
  input  logic        STOP,
  output logic        BUSY,
  output logic        DONE,
  output logic        DOUT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BIT  = 2'b01,
    ST_SYNC = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] ALPHA_LAST = CNT_W'(DIVIDER - 1);
  localparam logic [CNT_W-1:0] ALPHA_ONE  = CNT_W'(1);

  // Level of one bit cell position: 0=narrow,narrow  1=wide,wide  F=narrow,wide.
  function automatic logic trit_level(input logic [1:0] trit, input logic [4:0] pos);
    logic wide;
    case (trit)
      2'b00:   wide = 1'b0;
      2'b11:   wide = 1'b1;
      default: wide = pos[4];
    endcase
    if (wide) begin
      return (pos[3:0] < 4'd12);
    end else begin
      return (pos[3:0] < 4'd4);
    end
  endfunction

  state_t           state_r, state_n;
  logic [CNT_W-1:0] alpha_cnt_r, alpha_cnt_n;
  logic [6:0]       sub_r, sub_n;
  logic [3:0]       bit_idx_r, bit_idx_n;
  logic [3:0]       frames_left_r, frames_left_n;
  logic [3:0]       frame_count_r, frame_count_n;
  logic [23:0]      code_r, code_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             dout_r, dout_n;
  logic             alpha_tick_s;

  // Next-state, counter and output-level computation.
  always_comb begin
    state_n       = state_r;
    alpha_cnt_n   = alpha_cnt_r;
    sub_n         = sub_r;
    bit_idx_n     = bit_idx_r;
    frames_left_n = frames_left_r;
    frame_count_n = frame_count_r;
    code_n        = code_r;
    busy_n        = busy_r;
    done_n        = 1'b0;
    dout_n        = 1'b0;
    alpha_tick_s  = (alpha_cnt_r == ALPHA_LAST);

    case (state_r)
      ST_IDLE: begin
        alpha_cnt_n = {CNT_W{1'b0}};
        if (START) begin
          state_n       = ST_BIT;
          code_n        = CODE;
          frame_count_n = FRAME_COUNT;
          frames_left_n = FRAME_COUNT;
          sub_n         = 7'd0;
          bit_idx_n     = 4'd0;
          busy_n        = 1'b1;
        end else begin
          busy_n = 1'b0;
        end
      end

      ST_BIT: begin
        if (alpha_tick_s) begin
          alpha_cnt_n = {CNT_W{1'b0}};
          if (sub_r[4:0] == 5'd31) begin
            sub_n = 7'd0;
            if (bit_idx_r == 4'd11) begin
              state_n = ST_SYNC;
            end else begin
              bit_idx_n = bit_idx_r + 4'd1;
            end
          end else begin
            sub_n = sub_r + 7'd1;
          end
        end else begin
          alpha_cnt_n = alpha_cnt_r + ALPHA_ONE;
        end
      end

      ST_SYNC: begin
        if (alpha_tick_s) begin
          alpha_cnt_n = {CNT_W{1'b0}};
          if (sub_r == 7'd127) begin
            sub_n = 7'd0;
            // A latched count of zero means run until STOP, so never decrement.
            if (frame_count_r != 4'd0) begin
              frames_left_n = frames_left_r - 4'd1;
            end else begin
              frames_left_n = frames_left_r;
            end
            if (STOP || ((frame_count_r != 4'd0) && (frames_left_r == 4'd1))) begin
              state_n = ST_IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n   = ST_BIT;
              bit_idx_n = 4'd0;
            end
          end else begin
            sub_n = sub_r + 7'd1;
          end
        end else begin
          alpha_cnt_n = alpha_cnt_r + ALPHA_ONE;
        end
      end

      default: begin
        state_n     = ST_IDLE;
        busy_n      = 1'b0;
        alpha_cnt_n = {CNT_W{1'b0}};
      end
    endcase

    // DOUT is derived from the upcoming position so the register lines up with it.
    case (state_n)
      ST_BIT:  dout_n = trit_level(code_n[{bit_idx_n, 1'b0} +: 2], sub_n[4:0]);
      ST_SYNC: dout_n = (sub_n < 7'd4);
      default: dout_n = 1'b0;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge INPUT_CLK) begin
    if (RST) begin
      state_r       <= ST_IDLE;
      alpha_cnt_r   <= {CNT_W{1'b0}};
      sub_r         <= 7'd0;
      bit_idx_r     <= 4'd0;
      frames_left_r <= 4'd0;
      frame_count_r <= 4'd0;
      code_r        <= 24'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      dout_r        <= 1'b0;
    end else begin
      state_r       <= state_n;
      alpha_cnt_r   <= alpha_cnt_n;
      sub_r         <= sub_n;
      bit_idx_r     <= bit_idx_n;
      frames_left_r <= frames_left_n;
      frame_count_r <= frame_count_n;
      code_r        <= code_n;
      busy_r        <= busy_n;
      done_r        <= done_n;
      dout_r        <= dout_n;
    end
  end

  assign BUSY = busy_r;
  assign DONE = done_r;
  assign DOUT = dout_r;

endmodule

// File: tb/tb_pt2262_tx_sequencer.sv
// Self-checking bench for pt2262_tx_sequencer: DIVIDER=4 and DIVIDER=2 instances
// checked cycle by cycle against a waveform model built from the PT2262 rules.
module tb_pt2262_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v;
  logic        stop_v;
  logic        sel;
  logic [23:0] code_v;
  logic [3:0]  fc_v;
  logic        start_a, start_b;
  logic        busy_a, done_a, dout_a;
  logic        busy_b, done_b, dout_b;
  logic        busy_o, done_o, dout_o;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign start_a = start_v & ~sel;
  assign start_b = start_v & sel;
  assign busy_o  = sel ? busy_b : busy_a;
  assign done_o  = sel ? done_b : done_a;
  assign dout_o  = sel ? dout_b : dout_a;

  pt2262_tx_sequencer #(.DIVIDER(4), .CNT_W(16)) u_dut_a (
    .INPUT_CLK  (clk),
    .RST        (rst),
    .START      (start_a),
    .CODE       (code_v),
    .FRAME_COUNT(fc_v),
    .STOP       (stop_v),
    .BUSY       (busy_a),
    .DONE       (done_a),
    .DOUT       (dout_a)
  );

  pt2262_tx_sequencer #(.DIVIDER(2), .CNT_W(16)) u_dut_b (
    .INPUT_CLK  (clk),
    .RST        (rst),
    .START      (start_b),
    .CODE       (code_v),
    .FRAME_COUNT(fc_v),
    .STOP       (stop_v),
    .BUSY       (busy_b),
    .DONE       (done_b),
    .DOUT       (dout_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected DOUT for alpha index a (0..511) within a frame.
  function automatic logic model_dout(input logic [23:0] code, input int a);
    int          t, pos, p;
    logic [1:0]  trit;
    logic        wide;
    logic [23:0] sh;
    if (a < 384) begin
      t    = a / 32;
      sh   = code >> (2 * t);
      trit = sh[1:0];
      pos  = a % 32;
      p    = pos % 16;
      wide = (trit == 2'b11) || ((trit != 2'b00) && (pos >= 16));
      if (wide) return (p < 12);
      else      return (p < 4);
    end
    return ((a - 384) < 4);
  endfunction

  task automatic kick(input logic [23:0] code, input logic [3:0] fc);
    code_v  = code;
    fc_v    = fc;
    start_v = 1'b1;
    step();
    start_v = 1'b0;
  endtask

  // Checks every cycle of one transmission starting at cycle 1, ending in the DONE cycle.
  task automatic expect_tx(input string name, input logic [23:0] code, input int fc,
                           input int stop_at, input bit disturb);
    int   dv, fl, total;
    logic exp_d;
    dv    = sel ? 2 : 4;
    fl    = 512 * dv;
    total = (fc != 0) ? fc * fl : ((stop_at + fl - 1) / fl) * fl;
    for (int k = 1; k <= total; k++) begin
      exp_d = model_dout(code, ((k - 1) / dv) % 512);
      checks++;
      if ({busy_o, done_o, dout_o} !== {1'b1, 1'b0, exp_d}) begin
        errors++;
        $display("FAIL %s cycle %0d: busy/done/dout=%b/%b/%b expected 1/0/%b",
                 name, k, busy_o, done_o, dout_o, exp_d);
      end
      if ((stop_at != 0) && (k == stop_at)) stop_v = 1'b1;
      if (disturb) begin
        start_v = ($urandom_range(0, 99) == 0);
        if ($urandom_range(0, 49) == 0) begin
          code_v = $urandom;
          fc_v   = 4'($urandom);
        end
      end
      step();
    end
    start_v = 1'b0;
    checks++;
    if ({busy_o, done_o, dout_o} !== 3'b010) begin
      errors++;
      $display("FAIL %s done cycle %0d: busy/done/dout=%b/%b/%b expected 0/1/0",
               name, total + 1, busy_o, done_o, dout_o);
    end
    stop_v = 1'b0;
  endtask

  task automatic check_idle(input string name);
    step();
    checks++;
    if ({busy_o, done_o, dout_o} !== 3'b000) begin
      errors++;
      $display("FAIL %s idle: busy/done/dout=%b/%b/%b expected 0/0/0",
               name, busy_o, done_o, dout_o);
    end
  endtask

  task automatic test_reset();
    sel     = 1'b0;
    rst     = 1'b1;
    start_v = 1'b1;
    stop_v  = 1'b0;
    code_v  = $urandom;
    fc_v    = 4'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({busy_o, done_o, dout_o} !== 3'b000) begin
        errors++;
        $display("FAIL reset cycle %0d: busy/done/dout=%b/%b/%b expected 0/0/0",
                 i, busy_o, done_o, dout_o);
      end
    end
    rst     = 1'b0;
    start_v = 1'b0;
    check_idle("reset_release");
  endtask

  task automatic test_single();
    kick(24'h000000, 4'd1);
    expect_tx("single", 24'h000000, 1, 0, 1'b0);
    check_idle("single");
  endtask

  task automatic test_trit_mix();
    kick(24'h000007, 4'd1);
    expect_tx("trit_mix_01", 24'h000007, 1, 0, 1'b0);
    check_idle("trit_mix_01");
    kick(24'h00000B, 4'd1);
    expect_tx("trit_mix_10", 24'h00000B, 1, 0, 1'b0);
    check_idle("trit_mix_10");
  endtask

  task automatic test_random_codes();
    logic [23:0] c;
    for (int i = 0; i < 2; i++) begin
      c = $urandom;
      kick(c, 4'd1);
      expect_tx("random_code", c, 1, 0, 1'b0);
      check_idle("random_code");
    end
  endtask

  task automatic test_repeat();
    logic [23:0] c;
    c = $urandom;
    kick(c, 4'd3);
    expect_tx("repeat3", c, 3, 0, 1'b1);
    check_idle("repeat3");
  endtask

  task automatic test_continuous();
    logic [23:0] c;
    c = $urandom;
    kick(c, 4'd0);
    expect_tx("continuous", c, 0, 3000, 1'b0);
    check_idle("continuous");
  endtask

  task automatic test_abort();
    kick($urandom, 4'd1);
    for (int i = 0; i < 999; i++) step();
    rst = 1'b1;
    step();
    checks++;
    if ({busy_o, done_o, dout_o} !== 3'b000) begin
      errors++;
      $display("FAIL abort: busy/done/dout=%b/%b/%b expected 0/0/0",
               busy_o, done_o, dout_o);
    end
    rst = 1'b0;
    check_idle("abort_after");
  endtask

  task automatic test_back_to_back();
    logic [23:0] c1, c2;
    sel = 1'b1;
    c1  = $urandom;
    c2  = $urandom;
    kick(c1, 4'd1);
    expect_tx("b2b_first", c1, 1, 0, 1'b0);
    kick(c2, 4'd1);
    expect_tx("b2b_second", c2, 1, 0, 1'b0);
    check_idle("b2b");
    sel = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    sel     = 1'b0;
    start_v = 1'b0;
    stop_v  = 1'b0;
    code_v  = 24'd0;
    fc_v    = 4'd0;
    test_reset();
    test_single();
    test_trit_mix();
    test_random_codes();
    test_repeat();
    test_continuous();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pt2262_tx_sequencer.md
Name: pt2262_tx_sequencer

Overview:
Frame sequencer for the PT2262-compatible encoder path. It derives the encoder oscillator period (alpha) as a clock-enable from INPUT_CLK, using the same ratio the clock divider is configured with. It serialises a 12-trit address/data word plus sync into the PT2262 pulse waveform on DOUT and repeats the frame a programmed number of times. It sits between the host/control logic and the RF output pin, and replaces free-running divided clocks with a single-clock, enable-based schedule.

Parameters:
DIVIDER, 250, INPUT_CLK cycles per alpha; legal range 2..65535.
CNT_W, 16, width of the alpha prescaler counter; must hold DIVIDER-1.

Ports:
INPUT_CLK  input  1  system clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
START  input  1  request; sampled only in IDLE
CODE  input  24  12 trits, trit i = CODE[2i+1:2i]; 00=0, 11=1, 01=F, 10=F (reserved)
FRAME_COUNT  input  4  frames to send; 0 = continuous until STOP
STOP  input  1  level; end after current frame completes
BUSY  output  1  high while a transmission is in progress
DONE  output  1  one-cycle pulse at end of transmission
DOUT  output  1  PT2262 serial waveform

Behaviour:
- Reset values: BUSY=0, DONE=0, DOUT=0, state IDLE, all counters 0. RST has priority over every other input and aborts any frame immediately.
- Prescaler: alpha_cnt counts 0..DIVIDER-1 only while not IDLE. Alpha boundary occurs when alpha_cnt==DIVIDER-1. Each alpha is exactly DIVIDER cycles.
- States: IDLE, BIT, SYNC.
- IDLE: START=1 at edge E0 latches CODE and FRAME_COUNT and clears the counters. After E0: state=BIT, BUSY=1, DOUT=1, bit_idx=0, sub=0, frames_left=FRAME_COUNT. START is ignored outside IDLE; CODE and FRAME_COUNT changes are ignored while BUSY.
- BIT: sub counts 0..31 in alpha units. Half-bit h = sub[4], position p = sub[3:0].
  - Narrow half: DOUT=1 for p<4, else 0.
  - Wide half: DOUT=1 for p<12, else 0.
  - Trit 0 = narrow,narrow. Trit 1 = wide,wide. F = narrow,wide.
  - Trit 0 (CODE[1:0]) is sent first.
  - After sub=31 at the alpha boundary: bit_idx<11 -> bit_idx+1 and sub=0; bit_idx==11 -> SYNC with sub=0.
- SYNC: sub counts 0..127. DOUT=1 for sub<4, else 0. Frame length is 12*32+128 = 512 alpha = 512*DIVIDER cycles.
- End of SYNC (sub=127, alpha boundary): decrement frames_left unless the latched count is 0.
  - Ends the transmission if STOP=1 at that edge, or (latched count != 0 and frames_left==1).
  - Otherwise: BIT with bit_idx=0, sub=0, DOUT=1 on the next cycle. There is no gap between frames.
- End of transmission: next cycle state=IDLE, BUSY=0, DOUT=0, DONE=1 for exactly one cycle.
- START during the DONE cycle is accepted (back-to-back transmissions are allowed).
- STOP is sampled only at the frame-end edge. STOP asserted mid-frame never truncates a frame.
- DOUT is registered; no combinational path from inputs to outputs.

Test Plan (DIVIDER=4 unless noted):
- Reset: hold RST=1 for 3 cycles with START=1 -> BUSY=0, DONE=0, DOUT=0 throughout; START is not accepted until RST=0.
- Single frame, CODE=24'h000000, FRAME_COUNT=1 -> DOUT high 16 cycles, low 48, repeated 24 times. Then sync: high 16, low 496. BUSY high exactly 2048 cycles; DONE pulses once at cycle 2049.
- Trit mix, CODE with trit0=11, trit1=01, rest 00 -> first bit high 48/low 16/high 48/low 16. Second bit high 16/low 48/high 48/low 16. Code 10 yields a waveform identical to 01.
- Repeat, FRAME_COUNT=3 -> three contiguous 2048-cycle frames with no idle gap; a single DONE after 6144 cycles. START pulses mid-run are ignored and CODE changes mid-run do not alter DOUT.
- Continuous, FRAME_COUNT=0: assert STOP at cycle 3000 -> second frame completes; DONE at cycle 4097, then IDLE.
- Abort and boundary: RST at cycle 1000 -> DOUT=0 and BUSY=0 next cycle. With DIVIDER=2, START in the DONE cycle -> new frame begins with no gap; total frame length 1024 cycles.
